// File: rtl/typewriter_pacer.sv
// ---------------------------------------------------------------------------
// typewriter_pacer
//
// Paces one character at a time out to the IBM I/O writer behind the ANC-2
// coupler. A 5-bit output code is accepted from the I/O logic. The block then
// drives the level lines, fires the EXC (type) pulse with millisecond timing
// derived from tick_ms, and waits out the escapement. It checks the
// typewriter's LEV echo while EXC is high and reports ready/done to io_top.
//
// Ports
//   CLOCK     in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   tick_ms   in   1  one-CLOCK pulse per millisecond
//   req       in   1  output request, sampled only while ready=1
//   code      in   5  character code (OB5..OB1), latched on accept
//   an_mode   in   1  alphanumeric mode; when 0, lev[4] is forced to 0
//   abort     in   1  TYPE switch dropped / power clear, cancels at once
//   lev_echo  in   5  LEV5..LEV1 echo from the typewriter
//   ready     out  1  idle, a request can be accepted
//   done      out  1  one-cycle pulse when a character completes normally
//   exc       out  1  EXC type pulse to PL1-29
//   lev       out  5  level lines to the PL1 LEV IN pins
//   echo_err  out  1  sticky: the echo mismatched on the last character
//
// Phase lengths are counted in whole ticks. Because entering a phase is not
// aligned to tick_ms, a phase of N ms lasts between N-1 and N real ms.
// ---------------------------------------------------------------------------
module typewriter_pacer #(
    parameter int unsigned SETUP_MS = 2,
    parameter int unsigned PULSE_MS = 12,
    parameter int unsigned ESC_MS   = 40,
    parameter int unsigned CR_MS    = 250,
    parameter logic [4:0]  CR_CODE  = 5'b00100,
    parameter logic [4:0]  TAB_CODE = 5'b00110
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       req,
    input  logic [4:0] code,
    input  logic       an_mode,
    input  logic       abort,
    input  logic [4:0] lev_echo,
    output logic       ready,
    output logic       done,
    output logic       exc,
    output logic [4:0] lev,
    output logic       echo_err
);

    // -----------------------------------------------------------------------
    // Elaboration-time range checks. The ms counter is only 8 bits wide.
    // -----------------------------------------------------------------------
    if (SETUP_MS > 255) begin : g_bad_setup
        $error("typewriter_pacer: SETUP_MS must be <= 255");
    end
    if (PULSE_MS > 255) begin : g_bad_pulse
        $error("typewriter_pacer: PULSE_MS must be <= 255");
    end
    if (ESC_MS > 255) begin : g_bad_esc
        $error("typewriter_pacer: ESC_MS must be <= 255");
    end
    if (CR_MS > 255) begin : g_bad_cr
        $error("typewriter_pacer: CR_MS must be <= 255");
    end

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // A zero duration would let a phase pass without any tick at all. So it
    // is promoted to 1 ms, and every phase waits for at least one tick.
    function automatic logic [7:0] ms_load(input int unsigned ms);
        logic [7:0] v;
        v = ms[7:0];
        if (v == 8'd0) begin
            v = 8'd1;
        end
        return v;
    endfunction

    // In numeric mode the typewriter ignores LEV5, so the line is held low.
    function automatic logic [4:0] lev_mask(input logic [4:0] c,
                                            input logic       an);
        return {c[4] & an, c[3:0]};
    endfunction

    localparam logic [7:0] SETUP_LD = ms_load(SETUP_MS);
    localparam logic [7:0] PULSE_LD = ms_load(PULSE_MS);
    localparam logic [7:0] ESC_LD   = ms_load(ESC_MS);
    localparam logic [7:0] CR_LD    = ms_load(CR_MS);
    localparam logic [7:0] TAB_LD   = ms_load(CR_MS >> 1);

    // Carriage return and tab move the carriage much further than an
    // ordinary character, so they get longer escapement waits.
    function automatic logic [7:0] esc_load(input logic [4:0] c);
        logic [7:0] v;
        if (c == CR_CODE) begin
            v = CR_LD;
        end else if (c == TAB_CODE) begin
            v = TAB_LD;
        end else begin
            v = ESC_LD;
        end
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        PULSE  = 2'd2,
        ESCAPE = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [4:0] code_q;

    // PULSE ends on the tick that takes the counter to zero, so EXC is high
    // for exactly PULSE_MS ticks. The cnt==0 case cannot arise with a load
    // of at least 1, but it keeps the state from stalling if it ever did.
    logic pulse_end;
    assign pulse_end = tick_ms ? (cnt <= 8'd1) : (cnt == 8'd0);

    // -----------------------------------------------------------------------
    // Single registered FSM. All outputs are flops.
    // A load on phase entry takes priority over a same-cycle tick: the entry
    // branch never decrements. So a tick arriving in the cycle a phase is
    // entered does not count against that phase.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            exc      <= 1'b0;
            lev      <= 5'd0;
            echo_err <= 1'b0;
            code_q   <= 5'd0;
            cnt      <= 8'd0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Immediate cancel. echo_err keeps whatever it recorded.
                state <= IDLE;
                ready <= 1'b1;
                exc   <= 1'b0;
                lev   <= 5'd0;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            code_q   <= code;
                            lev      <= lev_mask(code, an_mode);
                            exc      <= 1'b0;
                            echo_err <= 1'b0;
                            cnt      <= SETUP_LD;
                            ready    <= 1'b0;
                            state    <= SETUP;
                        end
                    end

                    SETUP: begin
                        if (cnt == 8'd0) begin
                            cnt   <= PULSE_LD;
                            exc   <= 1'b1;
                            state <= PULSE;
                        end else if (tick_ms) begin
                            cnt <= cnt - 8'd1;
                        end
                    end

                    PULSE: begin
                        if (pulse_end) begin
                            // The echo is checked at the end of EXC. By then
                            // the typewriter's LEV contacts have settled.
                            if (lev_echo != lev) begin
                                echo_err <= 1'b1;
                            end
                            cnt   <= esc_load(code_q);
                            exc   <= 1'b0;
                            lev   <= 5'd0;
                            state <= ESCAPE;
                        end else if (tick_ms) begin
                            cnt <= cnt - 8'd1;
                        end
                    end

                    ESCAPE: begin
                        if (cnt == 8'd0) begin
                            // ready rises together with done. A held req
                            // is then taken on the very next edge.
                            done  <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
                        end else if (tick_ms) begin
                            cnt <= cnt - 8'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        ready <= 1'b1;
                        exc   <= 1'b0;
                        lev   <= 5'd0;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_typewriter_pacer.sv
// ---------------------------------------------------------------------------
// tb_typewriter_pacer
//
// Directed, table-driven bench for typewriter_pacer with the default timing
// parameters. tick_ms is driven once every 4 clocks. Phase lengths are
// measured as the number of ticks sampled on the edges that make up each
// phase.
// ---------------------------------------------------------------------------
module tb_typewriter_pacer;

    localparam int TICK_PERIOD = 4;
    localparam int BUDGET      = 5000;

    logic       CLOCK = 1'b0;
    logic       rst_n;
    logic       tick_ms;
    logic       req;
    logic [4:0] code;
    logic       an_mode;
    logic       abort;
    logic [4:0] lev_echo;
    logic       ready;
    logic       done;
    logic       exc;
    logic [4:0] lev;
    logic       echo_err;

    typewriter_pacer dut (
        .CLOCK    (CLOCK),
        .rst_n    (rst_n),
        .tick_ms  (tick_ms),
        .req      (req),
        .code     (code),
        .an_mode  (an_mode),
        .abort    (abort),
        .lev_echo (lev_echo),
        .ready    (ready),
        .done     (done),
        .exc      (exc),
        .lev      (lev),
        .echo_err (echo_err)
    );

    always #5 CLOCK = ~CLOCK;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle_n = 0;
    logic tick_seen;

    typedef struct {
        logic [4:0] code;
        logic       an;
        logic [4:0] echo;
        logic [4:0] exp_lev;
        int         exp_setup;
        int         exp_pulse;
        int         exp_esc;
        logic       exp_err;
    } vec_t;

    vec_t vecs [0:6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: the edge happens, then outputs are stable at the negedge.
    // tick_seen records whether tick_ms was high on that edge.
    task automatic cyc();
        @(posedge CLOCK);
        tick_seen = tick_ms;
        @(negedge CLOCK);
        cycle_n++;
        tick_ms = ((cycle_n % TICK_PERIOD) == 0);
    endtask

    task automatic run_char(input logic [4:0] c, input logic an,
                            input logic [4:0] echo,
                            output int t_setup, output int t_pulse,
                            output int t_esc, output logic [4:0] lev_acc,
                            output logic [4:0] lev_pul, output logic rdy_acc,
                            output logic err_acc, output logic ok);
        int b;
        code     = c;
        an_mode  = an;
        lev_echo = echo;
        req      = 1'b1;
        cyc();
        req     = 1'b0;
        lev_acc = lev;
        rdy_acc = ready;
        err_acc = echo_err;
        t_setup = 0;
        t_pulse = 0;
        t_esc   = 0;
        b       = 0;
        while (!exc && b < BUDGET) begin
            cyc(); b++;
            if (tick_seen) t_setup++;
        end
        lev_pul = lev;
        while (exc && b < BUDGET) begin
            cyc(); b++;
            if (tick_seen) t_pulse++;
        end
        while (!done && b < BUDGET) begin
            cyc(); b++;
            if (tick_seen) t_esc++;
        end
        ok = (b < BUDGET);
    endtask

    task automatic wait_exc(input logic level, output logic ok);
        int b;
        b = 0;
        while (exc !== level && b < BUDGET) begin
            cyc(); b++;
        end
        ok = (b < BUDGET);
    endtask

    initial begin
        int         ts, tp, te, nt;
        logic [4:0] la, lp;
        logic       ra, ea, ok, saw_done;

        vecs[0] = '{5'b10011, 1'b1, 5'b10011, 5'b10011, 2, 12, 40,  1'b0};
        vecs[1] = '{5'b00100, 1'b1, 5'b00100, 5'b00100, 2, 12, 250, 1'b0};
        vecs[2] = '{5'b00110, 1'b1, 5'b00110, 5'b00110, 2, 12, 125, 1'b0};
        vecs[3] = '{5'b11111, 1'b0, 5'b01111, 5'b01111, 2, 12, 40,  1'b0};
        vecs[4] = '{5'b00101, 1'b1, 5'b00000, 5'b00101, 2, 12, 40,  1'b1};
        vecs[5] = '{5'b00101, 1'b1, 5'b00101, 5'b00101, 2, 12, 40,  1'b0};
        vecs[6] = '{5'b11010, 1'b0, 5'b01010, 5'b01010, 2, 12, 40,  1'b0};

        rst_n    = 1'b0;
        tick_ms  = 1'b0;
        req      = 1'b0;
        code     = 5'd0;
        an_mode  = 1'b1;
        abort    = 1'b0;
        lev_echo = 5'd0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_exc", exc, 0);
        check("reset_lev", lev, 0);
        check("reset_echo_err", echo_err, 0);

        // Table rows run back-to-back. Each request is presented in the
        // cycle done is high.
        for (int i = 0; i < 7; i++) begin
            run_char(vecs[i].code, vecs[i].an, vecs[i].echo,
                     ts, tp, te, la, lp, ra, ea, ok);
            check($sformatf("v%0d_timeout", i), ok, 1);
            check($sformatf("v%0d_accepted", i), ra, 0);
            check($sformatf("v%0d_err_clear", i), ea, 0);
            check($sformatf("v%0d_lev_setup", i), la, vecs[i].exp_lev);
            check($sformatf("v%0d_lev_pulse", i), lp, vecs[i].exp_lev);
            check($sformatf("v%0d_setup_ticks", i), ts, vecs[i].exp_setup);
            check($sformatf("v%0d_pulse_ticks", i), tp, vecs[i].exp_pulse);
            check($sformatf("v%0d_esc_ticks", i), te, vecs[i].exp_esc);
            check($sformatf("v%0d_ready_w_done", i), ready, 1);
            check($sformatf("v%0d_echo_err", i), echo_err, vecs[i].exp_err);
        end
        cyc();
        check("done_one_cycle", done, 0);
        check("idle_ready", ready, 1);

        // Reset in the middle of PULSE clears outputs before the next edge.
        code = 5'b00101; an_mode = 1'b1; lev_echo = 5'b00101; req = 1'b1;
        cyc();
        req = 1'b0;
        wait_exc(1'b1, ok);
        check("rst_pulse_reach", ok, 1);
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        check("rst_async_exc", exc, 0);
        check("rst_async_lev", lev, 0);
        check("rst_async_ready", ready, 1);
        check("rst_async_err", echo_err, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset during ESCAPE after a mismatch clears the sticky error.
        code = 5'b00101; lev_echo = 5'b00000; req = 1'b1;
        cyc();
        req = 1'b0;
        wait_exc(1'b1, ok);
        wait_exc(1'b0, ok);
        check("rst_esc_reach", ok, 1);
        check("rst_esc_err_set", echo_err, 1);
        rst_n = 1'b0;
        #1;
        check("rst_esc_err_clr", echo_err, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Abort five ticks into ESCAPE: back to idle, no done, error kept.
        code = 5'b00101; lev_echo = 5'b00000; req = 1'b1;
        cyc();
        req = 1'b0;
        wait_exc(1'b1, ok);
        wait_exc(1'b0, ok);
        check("abort_reach", ok, 1);
        nt = 0;
        while (nt < 5) begin
            cyc();
            if (tick_seen) nt++;
        end
        check("abort_pre_busy", ready, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_exc", exc, 0);
        check("abort_lev", lev, 0);
        check("abort_err_kept", echo_err, 1);
        saw_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        // req together with abort in IDLE is not accepted.
        code = 5'b10011; lev_echo = 5'b10011; req = 1'b1; abort = 1'b1;
        cyc();
        check("req_abort_ready", ready, 1);
        check("req_abort_lev", lev, 0);
        cyc();
        req = 1'b0; abort = 1'b0;
        cyc();
        check("req_abort_idle", ready, 1);
        check("req_abort_err", echo_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
